reg_file: RTL
=============

// Module: reg_file
// PURPOSE
//  - General-purpose register file of the single-cycle CPU; sits directly upstream
//    of the ALU-source / write-back select muxes and supplies their A/B operands.
//  - Two combinational read ports, one clocked write port.
//  - Register 0 is hardwired to zero.
//  - Synchronous active-high reset clears the whole array.
// PARAMETERS
//  - DATA_W  32  width of each register and of all data ports
//  - ADDR_W  5   address width; depth = 2**ADDR_W registers (32)
// PORTS
//  - clk        in   1       system clock; all state updates on rising edge
//  - rst        in   1       synchronous reset, active-high
//  - RegWrite   in   1       write enable for the current cycle
//  - WriteReg   in   ADDR_W  destination register index
//  - WriteData  in   DATA_W  data to be written
//  - ReadReg1   in   ADDR_W  source register index, port 1
//  - ReadReg2   in   ADDR_W  source register index, port 2
//  - ReadData1  out  DATA_W  contents of ReadReg1 (combinational)
//  - ReadData2  out  DATA_W  contents of ReadReg2 (combinational)
// BEHAVIOUR
//  - Reset: on a rising clk edge with rst=1, every register becomes 0.
//    - rst has priority over RegWrite; a write presented in that cycle is dropped.
//    - Reset applied mid-program discards all state; no partial clear.
//  - Write:
//    - On a rising clk edge with rst=0 and RegWrite=1, reg[WriteReg] <= WriteData.
//    - Latency 1 cycle: the new value is visible on the read ports after that edge.
//    - RegWrite=0 leaves the array unchanged regardless of the WriteReg/WriteData values.
//  - Register 0:
//    - A write to index 0 is ignored; storage is never modified.
//    - A read of index 0 always returns 0.
//  - Read:
//    - Purely combinational from the array; no clock latency.
//    - Both ports are independent; ReadReg1 == ReadReg2 is legal and gives identical data.
//  - Read/write to the same index in one cycle:
//    - The result is set by the configuration described below.
//    - Index 0 returns 0 in every configuration.
//  - Outputs after reset and before any write: ReadData1 = ReadData2 = 0 for every index.
//  - Index range: all 2**ADDR_W indices are valid. There is no out-of-range case and no
//    wrap-around, because the address width covers the full depth.
//  - The block contains no X sources; outputs are never X once reset has been applied.
// CONFIGURATION
//  - Macro REG_FILE_BYPASS_EN.
//  - Defined (write-through bypass):
//    - When RegWrite=1, rst=0, WriteReg!=0 and ReadRegN==WriteReg, ReadDataN shows
//      WriteData combinationally in the same cycle.
//    - This applies to each port independently.
//    - When rst=1, there is no bypass and the stored value is shown.
//  - Undefined:
//    - ReadDataN shows the stored (pre-edge) value in the write cycle.
//    - The written value appears only after the clock edge.
// TESTING
//  - Reset: write 0xDEADBEEF to r5, then assert rst for 1 cycle.
//    -> ReadData1(r5) = 0; all 32 indices read 0.
//  - Write/read: write r1=0x00000011 and r2=0xFFFFFFFF on consecutive cycles.
//    -> ReadData1(r1) = 0x11 and ReadData2(r2) = 0xFFFFFFFF on the next cycle.
//  - r0 protection: RegWrite=1, WriteReg=0, WriteData=0x12345678.
//    -> ReadData1(r0) = 0 both before and after the edge.
//  - Same-cycle hazard: r7 holds 0xA; in one cycle write 0xB to r7 while reading r7 on both ports.
//    -> Output is 0xB pre-edge with REG_FILE_BYPASS_EN, 0xA without; 0xB post-edge in both cases.
//  - Reset vs write: rst=1 and RegWrite=1 with WriteReg=3, WriteData=0x55.
//    -> r3 = 0 after the edge.
//  - Disabled write: RegWrite=0, WriteReg=4, WriteData=0x99; r4 previously 0x1.
//    -> r4 remains 0x1.

Source files
------------

// File: rtl/reg_file.sv
// reg_file: general-purpose register file for the single-cycle CPU.
//
// Two combinational read ports and one clocked write port. Register 0 reads
// as zero and ignores writes. A synchronous active-high reset clears every
// register, and it takes priority over a write in the same cycle.
//
// Optional feature, selected by the macro REG_FILE_BYPASS_EN:
//   defined   - write-through bypass. While a write to a non-zero index is
//               pending (RegWrite=1, rst=0), a read port addressing that
//               index shows WriteData in the same cycle.
//   undefined - the read ports show the stored (pre-edge) value. The written
//               value is visible only after the clock edge.
//
// Ports:
//   clk        in   1       system clock; state updates on the rising edge
//   rst        in   1       synchronous reset, active-high
//   RegWrite   in   1       write enable for the current cycle
//   WriteReg   in   ADDR_W  destination register index
//   WriteData  in   DATA_W  data to be written
//   ReadReg1   in   ADDR_W  source register index, port 1
//   ReadReg2   in   ADDR_W  source register index, port 2
//   ReadData1  out  DATA_W  contents of ReadReg1 (combinational)
//   ReadData2  out  DATA_W  contents of ReadReg2 (combinational)
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  localparam int DEPTH = 1 << ADDR_W;

  // The reads are combinational, so the array is built from flops rather
  // than block RAM.
  logic [DATA_W-1:0] mem_reg [DEPTH];

  genvar gi;

  // Entry 0 is a constant zero with no storage behind it. A write to index 0
  // therefore has nothing to update, and a read of index 0 returns zero
  // without extra muxing.
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_regs
      if (gi == 0) begin : g_zero
        assign mem_reg[gi] = '0;
      end else begin : g_store
        always_ff @(posedge clk) begin
          if (rst) begin
            mem_reg[gi] <= '0;
          end else if (RegWrite && (WriteReg == ADDR_W'(gi))) begin
            mem_reg[gi] <= WriteData;
          end
        end
      end
    end
  endgenerate

  // The two read ports are identical. Gather their addresses and results
  // into arrays so a single generate loop builds both ports.
  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rdata [2];

  assign raddr[0]  = ReadReg1;
  assign raddr[1]  = ReadReg2;
  assign ReadData1 = rdata[0];
  assign ReadData2 = rdata[1];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rports
      always_comb begin
        rdata[gi] = mem_reg[raddr[gi]];
`ifdef REG_FILE_BYPASS_EN
        // Forward the pending write. The bypass is suppressed during reset
        // (the write is dropped) and for index 0 (which must read zero).
        if (RegWrite && !rst && (WriteReg != '0) && (raddr[gi] == WriteReg)) begin
          rdata[gi] = WriteData;
        end
`endif
      end
    end
  endgenerate

endmodule
